// File: rtl/ram_if.sv
// ram_if -- RAM port between the memory controller (master) and the RAM
// responder (slave).
//   ramREN   : read request, from master
//   ramWEN   : write request, from master
//   ramaddr  : byte address, from master
//   ramstore : write data, from master
//   ramload  : read data, from slave (valid while ramstate == ACCESS)
//   ramstate : FREE=0, BUSY=1, ACCESS=2, ERROR=3, from slave
interface ram_if;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;

    modport master (
        output ramREN, ramWEN, ramaddr, ramstore,
        input  ramload, ramstate
    );

    modport slave (
        input  ramREN, ramWEN, ramaddr, ramstore,
        output ramload, ramstate
    );
endinterface

// File: rtl/ram_responder.sv
// ram_responder -- word-addressed RAM model answering the memory controller's
// RAM port after a programmable number of BUSY cycles.
//   CLK      : clock, rising edge
//   RST      : asynchronous active-high reset
//   ram      : ram_if slave (ramREN/ramWEN/ramaddr/ramstore in,
//              ramload/ramstate out, both outputs registered)
//   dbgWEN   : backdoor write enable (bench preload)
//   dbgaddr  : backdoor word index
//   dbgstore : backdoor write data
//
// state  | meaning
// FREE   | idle, evaluating the port each cycle
// BUSY   | counting down the access latency on a latched request
// ACCESS | one cycle, ramload valid / write committed
// ERROR  | one cycle, invalid request seen, ramload = BAD1BAD1
module ram_responder #(
    parameter int LAT   = 2,
    parameter int DEPTH = 4096,
    parameter int DBGW  = 12
) (
    input  logic            CLK,
    input  logic            RST,
    ram_if.slave            ram,
    input  logic            dbgWEN,
    input  logic [DBGW-1:0] dbgaddr,
    input  logic [31:0]     dbgstore
);
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef struct packed {
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] store;
    } req_t;

    localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);
    localparam logic [3:0]  LAT_M1  = (LAT > 0) ? 4'(LAT - 1) : 4'd0;
    localparam logic [31:0] BAD_LOAD = 32'hBAD1_BAD1;

    logic [31:0] mem [0:DEPTH-1];

    ramstate_t   state, state_n;
    logic [3:0]  cnt, cnt_n;
    req_t        latch_q, latch_n;
    logic [31:0] load_q, load_n;

    req_t        live;
    logic        req, invalid, differ;
    logic        commit, c_wen;
    logic [IW-1:0] c_idx;
    logic [31:0] c_store;
    logic        dbg_ok;

    assign live    = '{ren: ram.ramREN, wen: ram.ramWEN, addr: ram.ramaddr, store: ram.ramstore};
    assign req     = ram.ramREN | ram.ramWEN;
    assign invalid = (ram.ramREN & ram.ramWEN)
                   | (ram.ramaddr[1:0] != 2'b00)
                   | ({2'b00, ram.ramaddr[31:2]} >= DEPTH_W);
    assign differ  = (live != latch_q);
    assign dbg_ok  = (32'(dbgaddr) < DEPTH_W);

    assign ram.ramstate = state;
    assign ram.ramload  = load_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= FREE;
            cnt     <= 4'd0;
            latch_q <= '0;
            load_q  <= 32'd0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            latch_q <= latch_n;
            load_q  <= load_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        latch_n = latch_q;
        load_n  = load_q;
        commit  = 1'b0;
        c_wen   = 1'b0;
        c_idx   = '0;
        c_store = '0;

        unique case (state)
            BUSY: begin
                if (!req) begin
                    state_n = FREE;
                end else if (differ) begin
                    // Initiator changed something mid-flight: a valid change
                    // costs a full restart, an invalid one is reported.
                    if (invalid) begin
                        state_n = ERROR;
                        load_n  = BAD_LOAD;
                    end else begin
                        cnt_n   = LAT_M1;
                        latch_n = live;
                    end
                end else if (cnt == 4'd0) begin
                    state_n = ACCESS;
                    commit  = 1'b1;
                    c_wen   = latch_q.wen;
                    c_idx   = latch_q.addr[IW+1:2];
                    c_store = latch_q.store;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            default: begin
                // FREE, ACCESS and ERROR all re-evaluate the port, so a
                // request still held after ACCESS starts a new transaction.
                if (!req) begin
                    state_n = FREE;
                end else if (invalid) begin
                    state_n = ERROR;
                    load_n  = BAD_LOAD;
                end else if (LAT == 0) begin
                    state_n = ACCESS;
                    commit  = 1'b1;
                    c_wen   = ram.ramWEN;
                    c_idx   = ram.ramaddr[IW+1:2];
                    c_store = ram.ramstore;
                end else begin
                    state_n = BUSY;
                    cnt_n   = LAT_M1;
                    latch_n = live;
                end
            end
        endcase

        // Write-first: a write returns its own data on ramload.
        if (commit) begin
            load_n = c_wen ? c_store : mem[c_idx];
        end
    end

    // Port commit is placed after the backdoor so it wins a same-word collision.
    // RST gating keeps a live LAT=0 request from writing while in reset.
    always_ff @(posedge CLK) begin
        if (dbgWEN && dbg_ok) begin
            mem[dbgaddr[IW-1:0]] <= dbgstore;
        end
        if (commit && c_wen && !RST) begin
            mem[c_idx] <= c_store;
        end
    end
endmodule

// File: tb/tb_ram_responder.sv
// tb_ram_responder -- directed bench for ram_responder (LAT=2, DEPTH=4096).
// Expected responses are queued when a request is driven and popped when the
// responder reports ACCESS or ERROR.
module tb_ram_responder;
    localparam int LAT   = 2;
    localparam int DEPTH = 4096;
    localparam int DBGW  = 12;

    localparam logic [1:0] S_FREE   = 2'd0;
    localparam logic [1:0] S_BUSY   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_ERROR  = 2'd3;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic            dbgWEN = 1'b0;
    logic [DBGW-1:0] dbgaddr = '0;
    logic [31:0]     dbgstore = '0;

    ram_if bus();

    ram_responder #(.LAT(LAT), .DEPTH(DEPTH), .DBGW(DBGW)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .ram      (bus),
        .dbgWEN   (dbgWEN),
        .dbgaddr  (dbgaddr),
        .dbgstore (dbgstore)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0]  st;
        logic [31:0] load;
        int          at;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem_m [0:DEPTH-1];
    int          t0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic ren, input logic wen, input logic [31:0] addr, input logic [31:0] store);
        bus.ramREN   = ren;
        bus.ramWEN   = wen;
        bus.ramaddr  = addr;
        bus.ramstore = store;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        tick();
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        dbgWEN   = 1'b1;
        dbgaddr  = DBGW'(idx);
        dbgstore = val;
        tick();
        dbgWEN   = 1'b0;
        mem_m[idx] = val;
    endtask

    task automatic push(input logic [1:0] st, input logic [31:0] load, input int at);
        exp_t e;
        e.st   = st;
        e.load = load;
        e.at   = at;
        sb.push_back(e);
    endtask

    task automatic wait_resp(input string tag);
        exp_t e;
        int   n;
        n = 0;
        while ((bus.ramstate == S_FREE || bus.ramstate == S_BUSY) && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_queued"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_state"}, 32'(bus.ramstate), 32'(e.st));
            chk({tag, "_load"}, bus.ramload, e.load);
            chk({tag, "_cycle"}, 32'(cyc), 32'(e.at));
        end
    endtask

    task automatic read_check(input logic [31:0] addr, input int idx, input string tag);
        t0 = cyc;
        drive(1'b1, 1'b0, addr, 32'd0);
        push(S_ACCESS, mem_m[idx], t0 + LAT + 1);
        wait_resp(tag);
        idle();
    endtask

    task automatic err_check(input logic ren, input logic wen, input logic [31:0] addr,
                             input logic [31:0] store, input string tag);
        t0 = cyc;
        drive(ren, wen, addr, store);
        push(S_ERROR, 32'hBAD1_BAD1, t0 + 1);
        wait_resp(tag);
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        chk({tag, "_one_cycle"}, 32'(bus.ramstate), 32'(S_FREE));
    endtask

    initial begin
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        RST = 1'b1;
        tick();
        tick();
        chk("reset_state", 32'(bus.ramstate), 32'(S_FREE));
        chk("reset_load", bus.ramload, 32'd0);
        RST = 1'b0;
        tick();

        preload(0, 32'h0F0F_0F0F);
        preload(4, 32'hDEAD_BEEF);
        preload(5, 32'h1234_5678);
        preload(8, 32'h0000_0000);
        preload(12, 32'hA5A5_A5A5);
        preload(DEPTH - 1, 32'hFEED_FACE);

        // Read latency: FREE, BUSY, BUSY, ACCESS; then held request repeats every LAT+1.
        t0 = cyc;
        drive(1'b1, 1'b0, 32'h10, 32'd0);
        push(S_ACCESS, mem_m[4], t0 + 3);
        chk("lat_c0_free", 32'(bus.ramstate), 32'(S_FREE));
        tick();
        chk("lat_c1_busy", 32'(bus.ramstate), 32'(S_BUSY));
        tick();
        chk("lat_c2_busy", 32'(bus.ramstate), 32'(S_BUSY));
        tick();
        wait_resp("lat_read");
        tick();
        push(S_ACCESS, mem_m[4], t0 + 6);
        wait_resp("held_read");
        idle();
        chk("idle_free", 32'(bus.ramstate), 32'(S_FREE));

        // Write held through ACCESS, then switch to a read of the same word.
        t0 = cyc;
        drive(1'b0, 1'b1, 32'h20, 32'hCAFE_F00D);
        push(S_ACCESS, 32'hCAFE_F00D, t0 + 3);
        wait_resp("wr_access");
        mem_m[8] = 32'hCAFE_F00D;
        tick();
        chk("wr_rehold_busy", 32'(bus.ramstate), 32'(S_BUSY));
        drive(1'b1, 1'b0, 32'h20, 32'd0);
        push(S_ACCESS, mem_m[8], t0 + 7);
        wait_resp("rd_after_wr");
        idle();

        // Address change mid-BUSY restarts the latency.
        t0 = cyc;
        drive(1'b1, 1'b0, 32'h10, 32'd0);
        tick();
        tick();
        chk("chg_c2_busy", 32'(bus.ramstate), 32'(S_BUSY));
        drive(1'b1, 1'b0, 32'h14, 32'd0);
        push(S_ACCESS, mem_m[5], t0 + 5);
        wait_resp("addr_change");
        idle();

        // Invalid requests: one ERROR cycle each, memory untouched.
        err_check(1'b0, 1'b1, 32'h2, 32'h7777_7777, "err_misalign");
        err_check(1'b1, 1'b1, 32'h10, 32'h9999_9999, "err_ren_wen");
        err_check(1'b0, 1'b1, 32'(4 * DEPTH), 32'h6666_6666, "err_range");
        tick();
        read_check(32'h0, 0, "after_err_w0");
        read_check(32'h10, 4, "after_err_w4");
        read_check(32'(4 * DEPTH - 4), DEPTH - 1, "top_word");

        // Dropped write: back to FREE, nothing written.
        drive(1'b0, 1'b1, 32'h30, 32'h0000_0055);
        tick();
        chk("drop_busy", 32'(bus.ramstate), 32'(S_BUSY));
        bus.ramWEN = 1'b0;
        tick();
        chk("drop_free", 32'(bus.ramstate), 32'(S_FREE));
        tick();
        read_check(32'h30, 12, "drop_read");

        // Reset mid-BUSY on a write: immediate FREE/0, write discarded.
        drive(1'b0, 1'b1, 32'h10, 32'h1111_1111);
        tick();
        tick();
        chk("rst_pre_busy", 32'(bus.ramstate), 32'(S_BUSY));
        RST = 1'b1;
        #1;
        chk("rst_async_state", 32'(bus.ramstate), 32'(S_FREE));
        chk("rst_async_load", bus.ramload, 32'd0);
        drive(1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        RST = 1'b0;
        tick();
        read_check(32'h10, 4, "rst_read");

        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ram_responder.md
# ram_responder

Word-addressed RAM model that sits on the far side of the memory controller's RAM port. It samples `ramREN`/`ramWEN`/`ramaddr`/`ramstore` and answers with `ramstate` (FREE/BUSY/ACCESS/ERROR) and `ramload` after a programmable access latency. It is the responder the memory controller's INSTR/WB/RAMREAD/RAMWRITE states wait on, and it also serves as the simulation memory for system benches.

## Interface
- `LAT`, default 2: BUSY cycles per transaction; legal range 0–15.
- `DEPTH`, default 4096: storage size in 32-bit words. Valid byte addresses are 0 .. 4*DEPTH-4.
- `DBGW`, default 12: width of the backdoor word index. Must satisfy 2^DBGW ≥ DEPTH.
- `CLK`, in, 1: clock, rising edge.
- `RST`, in, 1: asynchronous, active-high reset.
- `ramREN`, in, 1: read request.
- `ramWEN`, in, 1: write request.
- `ramaddr`, in, 32: byte address. Word index is `ramaddr[31:2]`.
- `ramstore`, in, 32: write data.
- `ramload`, out, 32: read data. Valid only while `ramstate`==ACCESS.
- `ramstate`, out, 2: ramstate_t from cpu_types_pkg. FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- `dbgWEN`, in, 1: backdoor write enable, for bench preload.
- `dbgaddr`, in, DBGW: backdoor word index.
- `dbgstore`, in, 32: backdoor write data.

## Operation
**Request definitions**
- A request is present when `ramREN | ramWEN`.
- A request is invalid when any of these holds:
  - `ramREN & ramWEN`
  - `ramaddr[1:0] != 0`
  - word index ≥ DEPTH

**Latched request**
- On acceptance, the block latches {REN, WEN, addr, store}.
- Each cycle in BUSY, the live inputs are compared against the latched copy.

**States** (the state register drives `ramstate` directly)
- FREE:
  - no request → FREE
  - invalid request → ERROR
  - valid request, LAT=0 → ACCESS
  - valid request, LAT>0 → BUSY, cnt=LAT-1, latch request
- BUSY:
  - request dropped → FREE; transaction aborted, no write
  - inputs differ from latch (valid) → restart: cnt=LAT-1, re-latch, stay BUSY
  - inputs differ from latch (invalid) → ERROR
  - cnt==0 → ACCESS
  - otherwise → cnt-1
- ACCESS, lasts exactly one cycle, then re-evaluates exactly as FREE does:
  - a request still held on the next edge is a new transaction
  - this is what back-to-back WB1→WB2 / RAMREAD1→RAMREAD2 rely on
- ERROR, lasts one cycle, then re-evaluates as FREE:
  - memory is never modified
  - `ramload`=32'hBAD1BAD1

**Commit**
- Happens on the edge that enters ACCESS, using the latched values (or the live values when LAT=0).
- Write: `mem[idx]`←store, and `ramload`←store (write-first).
- Read: `ramload`←`mem[idx]`.

**Backdoor and collisions**
- `dbgWEN` writes `mem[dbgaddr]` on any edge, independent of state.
- On the same edge and same word as a port commit, the port commit wins.

**Reset**
- Outputs: `ramstate`=FREE, `ramload`=0.
- Internal: cnt=0, latch=0.
- Memory contents are not reset.
- RST asserted mid-BUSY aborts the transaction with no write.

## Timing
- Outputs are registered; no combinational path from inputs to outputs.
- A request first present in cycle t produces:
  - cycle t: FREE
  - cycles t+1 .. t+LAT: BUSY
  - cycle t+LAT+1: ACCESS, with `ramload` valid and the write visible
- Initiator rule: hold request, address and data stable until ACCESS is seen. Any change costs a full restart.
- Throughput with a continuously held request: one ACCESS per LAT+1 cycles.
- A read issued in the cycle right after a write's ACCESS returns the new data.

## Test plan
- **Reset:** assert RST mid-BUSY on a write of 0x11111111 to 0x10 → `ramstate`=FREE and `ramload`=0 immediately; a later read of 0x10 returns its preloaded value.
- **Read latency, LAT=2:** preload word 4 = 32'hDEADBEEF; hold `ramREN`, `ramaddr`=0x10 from cycle 0 → FREE, BUSY, BUSY, then ACCESS in cycle 3 with `ramload`=DEADBEEF.
- **Back-to-back write then read:**
  - write 0xCAFEF00D to 0x20, held through ACCESS in cycle 3
  - switch to read 0x20 at the start of cycle 4 (immediately after that ACCESS)
  - → the read's ACCESS occurs in cycle 7 with `ramload`=CAFEF00D
- **Mid-BUSY address change:** read 0x10, change to 0x14 in cycle 2 → BUSY restarts; ACCESS in cycle 5 returns `mem[5]`.
- **Errors:**
  - `ramaddr`=0x2 → ERROR for one cycle, `ramload`=BAD1BAD1
  - REN&WEN both high → ERROR
  - `ramaddr`=4*DEPTH → ERROR
  - memory unchanged in all three cases
- **Request drop:** write 0x55 to 0x30, drop `ramWEN` while BUSY → FREE next cycle; a read of 0x30 returns the old value.
